// File: rtl/alu_serial_driver_if.sv
// Pin bundle between the serial driver and the 4-bit ALU / harness.
// The master view belongs to the driver; the slave view belongs to whatever feeds SIN and provides C.
interface alu_serial_driver_if;
   logic SIN;
   logic SIN_VALID;
   logic A0;
   logic A1;
   logic A2;
   logic A3;
   logic B0;
   logic B1;
   logic B2;
   logic B3;
   logic CTRL0;
   logic CTRL1;
   logic C0;
   logic C1;
   logic C2;
   logic C3;
   logic SOUT;
   logic SOUT_VALID;
   logic DONE;
   logic BUSY;

   modport master (
      input  SIN, SIN_VALID, C0, C1, C2, C3,
      output A0, A1, A2, A3, B0, B1, B2, B3, CTRL0, CTRL1,
      output SOUT, SOUT_VALID, DONE, BUSY
   );

   modport slave (
      output SIN, SIN_VALID, C0, C1, C2, C3,
      input  A0, A1, A2, A3, B0, B1, B2, B3, CTRL0, CTRL1,
      input  SOUT, SOUT_VALID, DONE, BUSY
   );
endinterface

// File: rtl/alu_serial_driver.sv
// Serial front end for the 4-bit ALU: loads a 10-bit operand frame, drives the ALU pins,
// waits SETTLE_CYCLES, samples C3..C0 and returns the result LSB first.
module alu_serial_driver #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input logic CLK,
   input logic RST,
`ifdef USE_POWER_PINS
   inout wire  vccd1,
   inout wire  vssd1,
`endif
   alu_serial_driver_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SETTLE,
      SHIFT_OUT
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q,     state_d;
   logic [8:0] shadow_q,    shadow_d;
   logic [3:0] bitCnt_q,    bitCnt_d;
   logic [9:0] pins_q,      pins_d;
   logic [3:0] settleCnt_q, settleCnt_d;
   logic [3:0] result_q,    result_d;
   logic [1:0] outIdx_q,    outIdx_d;
   logic       sout_q,      sout_d;
   logic       soutValid_q, soutValid_d;
   logic       done_q,      done_d;
   logic       busy_q,      busy_d;

   // All state, including the driven pins and serial outputs, clears the instant RST rises.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         shadow_q    <= '0;
         bitCnt_q    <= '0;
         pins_q      <= '0;
         settleCnt_q <= '0;
         result_q    <= '0;
         outIdx_q    <= '0;
         sout_q      <= 1'b0;
         soutValid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         bitCnt_q    <= bitCnt_d;
         pins_q      <= pins_d;
         settleCnt_q <= settleCnt_d;
         result_q    <= result_d;
         outIdx_q    <= outIdx_d;
         sout_q      <= sout_d;
         soutValid_q <= soutValid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   // Bits 0..8 shift in at the top of the shadow so bit 0 ends up at index 0; bit 9 goes
   // straight to the pins together with the shadow, so the pins never show a partial frame.
   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      bitCnt_d    = bitCnt_q;
      pins_d      = pins_q;
      settleCnt_d = settleCnt_q;
      result_d    = result_q;
      outIdx_d    = outIdx_q;
      sout_d      = sout_q;
      soutValid_d = soutValid_q;
      done_d      = 1'b0;
      busy_d      = busy_q;

      unique case (state_q)
         IDLE: begin
            if (bus.SIN_VALID) begin
               shadow_d = {bus.SIN, shadow_q[8:1]};
               bitCnt_d = 4'd1;
               busy_d   = 1'b1;
               state_d  = LOAD;
            end
         end

         LOAD: begin
            if (bus.SIN_VALID) begin
               if (bitCnt_q == 4'd9) begin
                  pins_d      = {bus.SIN, shadow_q};
                  bitCnt_d    = 4'd0;
                  settleCnt_d = 4'd0;
                  state_d     = SETTLE;
               end else begin
                  shadow_d = {bus.SIN, shadow_q[8:1]};
                  bitCnt_d = bitCnt_q + 4'd1;
               end
            end
         end

         SETTLE: begin
            if (settleCnt_q == SETTLE_LAST) begin
               result_d    = {bus.C3, bus.C2, bus.C1, bus.C0};
               sout_d      = bus.C0;
               soutValid_d = 1'b1;
               outIdx_d    = 2'd0;
               state_d     = SHIFT_OUT;
            end else begin
               settleCnt_d = settleCnt_q + 4'd1;
            end
         end

         SHIFT_OUT: begin
            if (outIdx_q == 2'd3) begin
               sout_d      = 1'b0;
               soutValid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end else begin
               outIdx_d = outIdx_q + 2'd1;
               sout_d   = result_q[outIdx_q + 2'd1];
               done_d   = (outIdx_q == 2'd2);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.A0         = pins_q[0];
   assign bus.A1         = pins_q[1];
   assign bus.A2         = pins_q[2];
   assign bus.A3         = pins_q[3];
   assign bus.B0         = pins_q[4];
   assign bus.B1         = pins_q[5];
   assign bus.B2         = pins_q[6];
   assign bus.B3         = pins_q[7];
   assign bus.CTRL0      = pins_q[8];
   assign bus.CTRL1      = pins_q[9];
   assign bus.SOUT       = sout_q;
   assign bus.SOUT_VALID = soutValid_q;
   assign bus.DONE       = done_q;
   assign bus.BUSY       = busy_q;

endmodule

// File: doc/alu_serial_driver.md
Name: alu_serial_driver

Overview:
Upstream/downstream companion stage for the 4-bit combinational ALU.
- Receives an operation serially: A, B and CTRL as a 10-bit frame on a single-bit input.
- Drives the ALU's A0..A3, B0..B3, CTRL0..CTRL1 pins from registers, waits a programmable settle time, then samples C0..C3.
- Returns the 4-bit result serially, which lets a low-pin-count harness exercise the ALU across the interconnect.

Parameters:
SETTLE_CYCLES, 2, number of cycles between driving operands and sampling C0..C3; legal range 1..15.

Ports:
CLK  input  1  single clock.
RST  input  1  reset, asynchronous, active-high.
vccd1  inout  1  1.8V supply; present only when USE_POWER_PINS is defined.
vssd1  inout  1  digital ground; present only when USE_POWER_PINS is defined.
SIN  input  1  serial frame data.
SIN_VALID  input  1  SIN is valid this cycle.
A0..A3  output  1 each  registered operand A to the ALU.
B0..B3  output  1 each  registered operand B to the ALU.
CTRL0, CTRL1  output  1 each  registered ALU op select.
C0..C3  input  1 each  ALU result.
SOUT  output  1  serial result bit.
SOUT_VALID  output  1  SOUT is valid.
DONE  output  1  one-cycle pulse with the last result bit.
BUSY  output  1  a frame is in progress.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high. All flops clear on RST high.
- Reset values: A0..A3, B0..B3, CTRL0/1, SOUT, SOUT_VALID, DONE and BUSY are all 0. State is IDLE.
- Frame format: 10 bits, one per cycle in which SIN_VALID=1 is accepted.
  - Bit order: A0, A1, A2, A3, B0, B1, B2, B3, CTRL0, CTRL1.
  - Bits accumulate in an internal shadow shift register. Driven ALU pins do not change during loading.
- State machine: IDLE, LOAD, SETTLE, SHIFT_OUT.
  - IDLE: SIN_VALID=1 accepts bit 0, sets bit count to 1, moves to LOAD, BUSY=1 from the next cycle.
  - LOAD: each SIN_VALID=1 accepts the next bit. SIN_VALID=0 holds state and bit count; gaps of any length are allowed and there is no timeout.
  - LOAD exit: on the edge accepting bit 9, the shadow register (including bit 9) is copied to A/B/CTRL outputs in the same edge. The settle counter clears and the state moves to SETTLE.
  - SETTLE: counter increments every cycle. On the edge where counter = SETTLE_CYCLES-1, C3..C0 are captured into a 4-bit result register and the state moves to SHIFT_OUT. Capture therefore occurs exactly SETTLE_CYCLES edges after the operand update.
  - SHIFT_OUT: for 4 consecutive cycles, SOUT = result bit i (i = 0..3, LSB first) with SOUT_VALID=1. DONE=1 only during the bit-3 cycle. The edge ending the bit-3 cycle returns to IDLE, with BUSY, SOUT_VALID and SOUT going to 0.
- Output hold: A/B/CTRL outputs hold their last values after the frame until the next frame's bit 9 is accepted.
- SIN_VALID outside IDLE/LOAD: ignored during SETTLE and SHIFT_OUT, including the DONE cycle. The first bit of the next frame is accepted no earlier than the cycle after DONE.
- Latency: from the edge accepting bit 9 to the first SOUT_VALID cycle is SETTLE_CYCLES cycles. The full frame-to-DONE time is 10 + SETTLE_CYCLES + 3 cycles with no gaps.
- Reset mid-operation (any state): immediate return to IDLE.
  - Partial frame and result are discarded.
  - A/B/CTRL outputs go to 0.
  - SOUT_VALID and DONE drop asynchronously.
  - No stale bit is emitted after RST deasserts.
- Width: result is exactly C3..C0 with no interpretation. The block does not compute ALU results itself.

Test Plan:
- Add: frame A=5, B=3, CTRL=0 (bits 1,0,1,0,1,1,0,0,0,0), no gaps -> A/B/CTRL pins = 0101/0011/00 after bit 9. SOUT sequence 0,0,0,1 (8). DONE with 4th bit at cycle 10+SETTLE_CYCLES+3.
- Sub wrap: A=2, B=3, CTRL=1 -> SOUT 1,1,1,1 (0xF). And: A=0xC, B=0xA, CTRL=2 -> SOUT 0,0,0,1 (0x8).
- Compare with gaps: A=9, B=4, CTRL=3, SIN_VALID low 3 cycles between bits 4 and 5 -> SOUT 1,0,0,0. Pins unchanged until bit 9 accepted. SIN_VALID pulses during SETTLE/SHIFT_OUT are ignored and do not corrupt the next frame.
- Settle sweep: SETTLE_CYCLES=1 and 15 -> C sampled exactly SETTLE_CYCLES edges after operand update. Check with a bench ALU model whose output is delayed SETTLE_CYCLES-1 cycles.
- Back-to-back: second frame bit 0 presented in the DONE cycle is ignored; the same bit presented the next cycle is accepted and the second result is correct.
- Reset mid-LOAD (after 6 bits) and mid-SHIFT_OUT (after bit 1) -> outputs 0 immediately. A fresh full frame afterwards produces the correct result with no leftover bits.
